// File: rtl/pixel_frame_writer.sv
// AXI4 write-burst master: drains packed pixel words and writes one frame as fixed INCR bursts.
// Optional macro DOUBLE_BUF_EN: ping-pong between two frame buffers at FRAME_BASE and FRAME_BASE+frame size.
module pixel_frame_writer #(
    parameter int                    DATA_W            = 32,
    parameter int                    ADDR_W            = 32,
    parameter int                    MST_ID_W          = 5,
    parameter int                    TRANS_DATA_LEN_W  = 8,
    parameter int                    TRANS_DATA_SIZE_W = 3,
    parameter int                    TRANS_RESP_W      = 2,
    parameter logic [MST_ID_W-1:0]   MST_ID            = 5'd1,
    parameter int                    BURST_LEN         = 16,
    parameter int                    FRAME_WORDS       = 4800,
    parameter logic [ADDR_W-1:0]     FRAME_BASE        = 32'h0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         frame_start_i,
    input  logic [DATA_W-1:0]            pxl_data_i,
    input  logic                         pxl_valid_i,
    output logic                         pxl_ready_o,
    output logic [MST_ID_W-1:0]          s_awid_o,
    output logic [ADDR_W-1:0]            s_awaddr_o,
    output logic [TRANS_DATA_LEN_W-1:0]  s_awlen_o,
    output logic [TRANS_DATA_SIZE_W-1:0] s_awsize_o,
    output logic                         s_awvalid_o,
    input  logic                         s_awready_i,
    output logic [DATA_W-1:0]            s_wdata_o,
    output logic                         s_wlast_o,
    output logic                         s_wvalid_o,
    input  logic                         s_wready_i,
    input  logic [MST_ID_W-1:0]          s_bid_i,
    input  logic [TRANS_RESP_W-1:0]      s_bresp_i,
    input  logic                         s_bvalid_i,
    output logic                         s_bready_o,
    output logic                         frame_done_o,
    output logic                         ovr_o,
    output logic                         err_o,
    output logic                         buf_sel_o
);

    localparam int NUM_BURSTS  = FRAME_WORDS / BURST_LEN;
    localparam int BURST_CNT_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;

    localparam logic [TRANS_DATA_LEN_W-1:0]  AW_LEN      = TRANS_DATA_LEN_W'(BURST_LEN - 1);
    localparam logic [TRANS_DATA_SIZE_W-1:0] AW_SIZE     = TRANS_DATA_SIZE_W'($clog2(DATA_W / 8));
    localparam logic [ADDR_W-1:0]            BURST_BYTES = ADDR_W'(BURST_LEN * (DATA_W / 8));
    localparam logic [BURST_CNT_W-1:0]       LAST_BURST  = BURST_CNT_W'(NUM_BURSTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_t;

    state_t                        r_state;
    logic [ADDR_W-1:0]             r_addr;
    logic [TRANS_DATA_LEN_W-1:0]   r_beat;
    logic [BURST_CNT_W-1:0]        r_burst;
    logic                          r_frame_done;
    logic                          r_ovr;
    logic                          r_err;

    logic                          w_in_w;
    logic                          w_w_hs;
    logic [ADDR_W-1:0]             w_frame_base;

`ifdef DOUBLE_BUF_EN
    localparam logic [ADDR_W-1:0] FRAME_BYTES = ADDR_W'(FRAME_WORDS * (DATA_W / 8));

    logic r_cur;
    logic r_buf_sel;
    logic w_frame_end;

    assign w_frame_end  = (r_state == ST_B) & s_bvalid_i & (r_burst == LAST_BURST);
    assign w_frame_base = r_cur ? (FRAME_BASE + FRAME_BYTES) : FRAME_BASE;
    assign buf_sel_o    = r_buf_sel;

    // buf_sel_o reports the buffer just completed; r_cur already points at the next one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cur     <= 1'b0;
            r_buf_sel <= 1'b0;
        end else if (w_frame_end) begin
            r_cur     <= ~r_cur;
            r_buf_sel <= r_cur;
        end
    end
`else
    assign w_frame_base = FRAME_BASE;
    assign buf_sel_o    = 1'b0;
`endif

    // NOTE: the W channel is a zero-latency combinational path from the FIFO; no data register.
    assign w_in_w      = (r_state == ST_W);
    assign w_w_hs      = w_in_w & pxl_valid_i & s_wready_i;
    assign pxl_ready_o = w_w_hs;
    assign s_wvalid_o  = w_in_w & pxl_valid_i;
    assign s_wdata_o   = pxl_data_i;
    assign s_wlast_o   = w_in_w & (r_beat == AW_LEN);

    assign s_awid_o    = MST_ID;
    assign s_awaddr_o  = r_addr;
    assign s_awlen_o   = AW_LEN;
    assign s_awsize_o  = AW_SIZE;
    assign s_awvalid_o = (r_state == ST_AW);
    assign s_bready_o  = (r_state == ST_B);

    assign frame_done_o = r_frame_done;
    assign ovr_o        = r_ovr;
    assign err_o        = r_err;

    // NOTE: reset is asynchronous and active-high; every state register is cleared here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_addr       <= FRAME_BASE;
            r_beat       <= '0;
            r_burst      <= '0;
            r_frame_done <= 1'b0;
            r_ovr        <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_ovr        <= frame_start_i & (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (frame_start_i) begin
                        r_state <= ST_AW;
                        r_addr  <= w_frame_base;
                        r_beat  <= '0;
                        r_burst <= '0;
                        r_err   <= 1'b0;
                    end
                end
                ST_AW: begin
                    if (s_awready_i) begin
                        r_state <= ST_W;
                        r_addr  <= r_addr + BURST_BYTES;
                    end
                end
                ST_W: begin
                    if (w_w_hs) begin
                        if (r_beat == AW_LEN) begin
                            r_beat  <= '0;
                            r_state <= ST_B;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                ST_B: begin
                    if (s_bvalid_i) begin
                        // A bad response is flagged but the burst still counts toward the frame.
                        if ((s_bresp_i != '0) || (s_bid_i != MST_ID)) begin
                            r_err <= 1'b1;
                        end
                        if (r_burst == LAST_BURST) begin
                            r_burst      <= '0;
                            r_state      <= ST_IDLE;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_burst <= r_burst + 1'b1;
                            r_state <= ST_AW;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Directed bench for pixel_frame_writer (BURST_LEN=4, FRAME_WORDS=8, FRAME_BASE=0x1000, MST_ID=1).
// Expected buffer addresses follow DOUBLE_BUF_EN when it is defined for the build.
module tb_pixel_frame_writer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        frame_start_i;
    logic [31:0] pxl_data_i;
    logic        pxl_valid_i;
    logic        pxl_ready_o;
    logic [4:0]  s_awid_o;
    logic [31:0] s_awaddr_o;
    logic [7:0]  s_awlen_o;
    logic [2:0]  s_awsize_o;
    logic        s_awvalid_o;
    logic        s_awready_i;
    logic [31:0] s_wdata_o;
    logic        s_wlast_o;
    logic        s_wvalid_o;
    logic        s_wready_i;
    logic [4:0]  s_bid_i;
    logic [1:0]  s_bresp_i;
    logic        s_bvalid_i;
    logic        s_bready_o;
    logic        frame_done_o;
    logic        ovr_o;
    logic        err_o;
    logic        buf_sel_o;

    pixel_frame_writer #(
        .BURST_LEN   (4),
        .FRAME_WORDS (8),
        .FRAME_BASE  (32'h1000),
        .MST_ID      (5'd1)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .frame_start_i (frame_start_i),
        .pxl_data_i    (pxl_data_i),
        .pxl_valid_i   (pxl_valid_i),
        .pxl_ready_o   (pxl_ready_o),
        .s_awid_o      (s_awid_o),
        .s_awaddr_o    (s_awaddr_o),
        .s_awlen_o     (s_awlen_o),
        .s_awsize_o    (s_awsize_o),
        .s_awvalid_o   (s_awvalid_o),
        .s_awready_i   (s_awready_i),
        .s_wdata_o     (s_wdata_o),
        .s_wlast_o     (s_wlast_o),
        .s_wvalid_o    (s_wvalid_o),
        .s_wready_i    (s_wready_i),
        .s_bid_i       (s_bid_i),
        .s_bresp_i     (s_bresp_i),
        .s_bvalid_i    (s_bvalid_i),
        .s_bready_o    (s_bready_o),
        .frame_done_o  (frame_done_o),
        .ovr_o         (ovr_o),
        .err_o         (err_o),
        .buf_sel_o     (buf_sel_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] fifo[$];
    logic [31:0] exp_q[$];
    logic [31:0] wq[$];
    logic        wl_q[$];
    logic [31:0] aw_q[$];

    int pop_cnt, done_cnt, ovr_cnt, b_cnt, pending_b;
    int err_idx, bid_err_idx, last_b_cyc, done_cyc;
    logic aw_rdy, toggle_valid, rand_wready;
    logic [15:0] wr_pat = 16'hB6D3;
    logic [7:0]  last_awlen;
    logic [2:0]  last_awsize;
    logic [4:0]  last_awid;
    logic        snap_awvalid, snap_wvalid, snap_err, snap_bufsel, snap_pxl_ready;
    logic [31:0] snap_awaddr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_base(input int idx);
`ifdef DOUBLE_BUF_EN
        return ((idx % 2) == 1) ? 32'h1020 : 32'h1000;
`else
        return 32'h1000;
`endif
    endfunction

    function automatic logic exp_bufsel(input int idx);
`ifdef DOUBLE_BUF_EN
        return ((idx % 2) == 1);
`else
        return 1'b0;
`endif
    endfunction

    // One clock: observe handshakes mid-cycle, then update the FIFO and slave models after the edge.
    task automatic tick();
        logic popped, wlast_hs, b_hs;
        @(negedge clk_i);
        popped   = pxl_ready_o;
        wlast_hs = s_wvalid_o && s_wready_i && s_wlast_o;
        b_hs     = s_bvalid_i && s_bready_o;
        if (s_awvalid_o && s_awready_i) begin
            aw_q.push_back(s_awaddr_o);
            last_awlen  = s_awlen_o;
            last_awsize = s_awsize_o;
            last_awid   = s_awid_o;
        end
        if (s_wvalid_o && s_wready_i) begin
            wq.push_back(s_wdata_o);
            wl_q.push_back(s_wlast_o);
        end
        if (popped) pop_cnt++;
        if (b_hs) last_b_cyc = cyc;
        if (frame_done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (ovr_o) ovr_cnt++;
        snap_awvalid   = s_awvalid_o;
        snap_awaddr    = s_awaddr_o;
        snap_wvalid    = s_wvalid_o;
        snap_err       = err_o;
        snap_bufsel    = buf_sel_o;
        snap_pxl_ready = pxl_ready_o;
        @(posedge clk_i);
        #1;
        cyc++;
        if (popped && fifo.size() > 0) void'(fifo.pop_front());
        if (wlast_hs) pending_b++;
        if (b_hs) begin
            pending_b--;
            b_cnt++;
        end
        pxl_valid_i = (fifo.size() > 0) && (!toggle_valid || cyc[0]);
        pxl_data_i  = (fifo.size() > 0) ? fifo[0] : 32'h0;
        s_wready_i  = rand_wready ? wr_pat[cyc % 16] : 1'b1;
        s_awready_i = aw_rdy;
        s_bvalid_i  = (pending_b > 0);
        s_bresp_i   = (b_cnt == err_idx) ? 2'b10 : 2'b00;
        s_bid_i     = (b_cnt == bid_err_idx) ? 5'd2 : 5'd1;
    endtask

    task automatic begin_test();
        aw_q.delete();
        wq.delete();
        wl_q.delete();
        exp_q.delete();
        pop_cnt = 0;
        ovr_cnt = 0;
        b_cnt   = 0;
    endtask

    task automatic load_fifo(input int idx);
        logic [31:0] w;
        for (int i = 0; i < 8; i++) begin
            w = 32'hC0DE_0000 | (32'(idx) << 8) | 32'(i);
            fifo.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    task automatic start_frame();
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int d0, n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_done_in_time"}, (done_cnt == d0) ? 0 : 1, 1);
    endtask

    task automatic frame_checks(input string tag, input int idx, input int exp_ovr);
        logic [31:0] a0, a1, d;
        logic [7:0]  lv;
        a0 = (aw_q.size() > 0) ? aw_q[0] : 32'hDEAD_BEEF;
        a1 = (aw_q.size() > 1) ? aw_q[1] : 32'hDEAD_BEEF;
        check({tag, "_aw_count"}, aw_q.size(), 2);
        check({tag, "_aw0_addr"}, a0, exp_base(idx));
        check({tag, "_aw1_addr"}, a1, exp_base(idx) + 32'h10);
        check({tag, "_w_count"}, wq.size(), 8);
        lv = '0;
        for (int i = 0; i < 8; i++) begin
            d = (i < wq.size()) ? wq[i] : 32'hFFFF_FFFF;
            check($sformatf("%s_wdata%0d", tag, i), d, exp_q[i]);
            lv[i] = (i < wl_q.size()) ? wl_q[i] : 1'b0;
        end
        check({tag, "_wlast_pos"}, lv, 8'b1000_1000);
        check({tag, "_pops"}, pop_cnt, 8);
        check({tag, "_fifo_empty"}, fifo.size(), 0);
        check({tag, "_done_lat"}, done_cyc - last_b_cyc, 1);
        check({tag, "_buf_sel"}, snap_bufsel, exp_bufsel(idx));
        check({tag, "_ovr_count"}, ovr_cnt, exp_ovr);
    endtask

    initial begin
        rst_i         = 1'b1;
        frame_start_i = 1'b0;
        pxl_data_i    = '0;
        pxl_valid_i   = 1'b0;
        s_awready_i   = 1'b0;
        s_wready_i    = 1'b0;
        s_bid_i       = 5'd1;
        s_bresp_i     = 2'b00;
        s_bvalid_i    = 1'b0;
        aw_rdy        = 1'b1;
        toggle_valid  = 1'b0;
        rand_wready   = 1'b0;
        err_idx       = -1;
        bid_err_idx   = -1;
        done_cnt      = 0;
        pending_b     = 0;
        last_b_cyc    = 0;
        done_cyc      = 0;
        begin_test();
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_awvalid", s_awvalid_o, 1'b0);
        check("rst_wvalid", s_wvalid_o, 1'b0);
        check("rst_bready", s_bready_o, 1'b0);
        check("rst_pxl_ready", pxl_ready_o, 1'b0);
        check("rst_frame_done", frame_done_o, 1'b0);
        check("rst_ovr", ovr_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_buf_sel", buf_sel_o, 1'b0);
        check("rst_awaddr", s_awaddr_o, 32'h1000);
        rst_i = 1'b0;
        tick();

        // 1: basic frame with ready slaves
        begin_test();
        load_fifo(0);
        start_frame();
        wait_done("t1");
        frame_checks("t1", 0, 0);
        check("t1_awlen", last_awlen, 8'd3);
        check("t1_awsize", last_awsize, 3'd2);
        check("t1_awid", last_awid, 5'd1);
        check("t1_err", snap_err, 1'b0);

        // 2: AW stall holds address stable, no W beats before acceptance
        begin_test();
        aw_rdy = 1'b0;
        load_fifo(1);
        start_frame();
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t2_awvalid_stall%0d", i), snap_awvalid, 1'b1);
            check($sformatf("t2_awaddr_stall%0d", i), snap_awaddr, exp_base(1));
            check($sformatf("t2_wvalid_stall%0d", i), snap_wvalid, 1'b0);
        end
        aw_rdy = 1'b1;
        wait_done("t2");
        frame_checks("t2", 1, 0);

        // 3: idle pixels not popped; then gappy FIFO and irregular wready
        begin_test();
        load_fifo(2);
        repeat (3) tick();
        check("t3_idle_pops", pop_cnt, 0);
        check("t3_idle_ready", snap_pxl_ready, 1'b0);
        toggle_valid = 1'b1;
        rand_wready  = 1'b1;
        start_frame();
        wait_done("t3");
        frame_checks("t3", 2, 0);
        toggle_valid = 1'b0;
        rand_wready  = 1'b0;

        // 4a: SLVERR on first burst is sticky through the following OKAY
        begin_test();
        err_idx = 0;
        load_fifo(3);
        start_frame();
        wait_done("t4a");
        frame_checks("t4a", 3, 0);
        check("t4a_err_at_done", snap_err, 1'b1);
        err_idx = -1;
        repeat (3) tick();
        check("t4a_err_sticky", snap_err, 1'b1);

        // 4b: next accepted frame_start clears err
        begin_test();
        load_fifo(4);
        start_frame();
        tick();
        check("t4b_err_cleared", snap_err, 1'b0);
        wait_done("t4b");
        frame_checks("t4b", 4, 0);
        check("t4b_err_end", snap_err, 1'b0);

        // 4c: BID mismatch on last burst sets err
        begin_test();
        bid_err_idx = 1;
        load_fifo(5);
        start_frame();
        wait_done("t4c");
        frame_checks("t4c", 5, 0);
        check("t4c_err_bid", snap_err, 1'b1);
        bid_err_idx = -1;

        // 5: frame_start during W of burst 0 -> single ovr pulse, frame unaffected
        begin_test();
        load_fifo(6);
        start_frame();
        for (int n = 0; n < 20 && wq.size() < 1; n++) tick();
        check("t5_in_w", (wq.size() >= 1) ? 1 : 0, 1);
        start_frame();
        wait_done("t5");
        frame_checks("t5", 6, 1);

        // reset mid-burst returns to IDLE immediately
        begin_test();
        load_fifo(7);
        start_frame();
        for (int n = 0; n < 20 && wq.size() < 2; n++) tick();
        rst_i = 1'b1;
        #2;
        check("mrst_awvalid", s_awvalid_o, 1'b0);
        check("mrst_wvalid", s_wvalid_o, 1'b0);
        check("mrst_pxl_ready", pxl_ready_o, 1'b0);
        check("mrst_bready", s_bready_o, 1'b0);
        check("mrst_awaddr", s_awaddr_o, 32'h1000);
        check("mrst_buf_sel", buf_sel_o, 1'b0);
        check("mrst_err", err_o, 1'b0);
        #20;
        rst_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
